// File: rtl/fifo_stream_reader_pkg.sv
// Shared helpers for the FIFO stream reader and its skid buffer.
package fifo_stream_reader_pkg;

    // Pointer width for a circular buffer; a depth of one still needs one bit.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buffer.sv
// Circular skid buffer: push/pop in the same cycle, head word read straight from a register.
// Count tracks occupancy; caller guarantees no push when full unless popping.
module fifo_stream_reader_skid_buffer
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_WIDTH = $clog2(BUF_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int PTR_W = ptr_bits(BUF_DEPTH);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns a one-cycle-latency rd_en/empty FIFO into a bubble-free valid/ready stream.
// Reads are issued only when the word will have a buffer slot once it lands.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_WIDTH = $clog2(BUF_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             idle
);

    localparam int SUM_W = CNT_WIDTH + 1;

    logic [CNT_WIDTH-1:0] count;
    logic                 inflight;
    logic                 pop;
    logic [SUM_W-1:0]     occ_next;

    assign pop = out_valid & out_ready;

    // Occupancy once this cycle's landing word and pop settle; a pop always has count>=1.
    assign occ_next   = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop);
    assign fifo_rd_en = rst_n & ~fifo_empty & (occ_next < SUM_W'(BUF_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_stream_reader_skid_buffer #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (out_data),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign idle      = (count == '0) & ~inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, in-order scoreboard, directed and random traffic.
module tb_fifo_stream_reader;

    localparam int WIDTH     = 8;
    localparam int BUF_DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             idle;

    fifo_stream_reader #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model: dout registered on an accepted read, empty registered, sync reset.
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] wr_words[8];
    logic [WIDTH-1:0] fifo_tmp;
    int               wr_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            fq.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() > 0) begin
                fifo_tmp = fq.pop_front();
                fifo_dout <= fifo_tmp;
            end
            for (int i = 0; i < wr_cnt; i++) fq.push_back(wr_words[i]);
            fifo_empty <= (fq.size() == 0);
        end
    end

    int               errors;
    int               checks;
    logic [WIDTH-1:0] exp_q[$];
    int               outstanding;
    int               delivered;
    logic             prev_hold;
    logic [WIDTH-1:0] prev_data;

    typedef struct {
        logic             ready;
        logic             rd_en;
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             idle;
    } vec_t;
    vec_t tbl[7];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle scoreboard: words leave in write order, held words stay put, never over-read.
    task automatic monitor();
        logic pop;
        if (!rst_n) return;
        pop = out_valid && out_ready;
        if (fifo_rd_en) check_eq("rd_en_while_empty", fifo_empty, 0);
        if (prev_hold) begin
            check_eq("held_valid", out_valid, 1);
            check_eq("held_data", out_data, prev_data);
        end
        check_eq("idle_vs_outstanding", idle, outstanding == 0);
        if (pop) begin
            check_eq("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("stream_data", out_data, exp_q.pop_front());
            delivered++;
        end
        outstanding = outstanding + int'(fifo_rd_en) - int'(pop);
        check_eq("occupancy_bound", outstanding <= BUF_DEPTH, 1);
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        wr_cnt = 0;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        wr_words[wr_cnt] = w;
        wr_cnt++;
        exp_q.push_back(w);
    endtask

    initial begin
        int base, reads, first, last, written, pct, n;
        rst_n = 1'b0;
        out_ready = 1'b0;
        wr_cnt = 0;
        errors = 0;
        checks = 0;
        outstanding = 0;
        delivered = 0;
        prev_hold = 1'b0;
        prev_data = '0;

        //            ready rd_en valid data   idle
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h44, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_rd_en", fifo_rd_en, 0);
        check_eq("reset_idle", idle, 1);
        rst_n = 1'b1;
        step();
        step();

        // Four preloaded words, consumer always ready.
        out_ready = 1'b1;
        base = delivered;
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        advance();
        for (int i = 0; i < 7; i++) begin
            out_ready = tbl[i].ready;
            sample();
            check_eq($sformatf("t1_rd_en[%0d]", i), fifo_rd_en, tbl[i].rd_en);
            check_eq($sformatf("t1_valid[%0d]", i), out_valid, tbl[i].valid);
            check_eq($sformatf("t1_idle[%0d]", i), idle, tbl[i].idle);
            if (tbl[i].valid) check_eq($sformatf("t1_data[%0d]", i), out_data, tbl[i].data);
            advance();
        end
        check_eq("t1_count", delivered - base, 4);

        // Eight words under backpressure: only the buffer depth is read ahead.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
        advance();
        reads = 0;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (fifo_rd_en) reads++;
            advance();
        end
        check_eq("t2_reads", reads, 2);
        check_eq("t2_valid", out_valid, 1);
        check_eq("t2_head", out_data, 8'hA0);
        check_eq("t2_idle", idle, 0);
        out_ready = 1'b1;
        base = delivered; first = -1; last = -1;
        for (int k = 0; k < 20; k++) begin
            sample();
            if (out_valid && out_ready) begin
                if (first < 0) first = k;
                last = k;
            end
            advance();
        end
        check_eq("t2_count", delivered - base, 8);
        check_eq("t2_back_to_back", last - first, 7);

        // Consumer ready toggling every cycle.
        for (int i = 0; i < 6; i++) push_word(8'hC0 + 8'(i));
        advance();
        base = delivered;
        for (int k = 0; k < 40 && (delivered - base) < 6; k++) begin
            out_ready = (k % 2 == 0);
            step();
        end
        check_eq("t3_count", delivered - base, 6);
        out_ready = 1'b1;
        repeat (4) step();

        // FIFO runs dry while the last word is still in flight.
        base = delivered;
        push_word(8'h01); push_word(8'h02); push_word(8'h03);
        advance();
        for (int k = 0; k < 8; k++) begin
            sample();
            if (k == 3) begin
                check_eq("t4_empty", fifo_empty, 1);
                check_eq("t4_rd_en_when_empty", fifo_rd_en, 0);
                check_eq("t4_inflight_not_idle", idle, 0);
            end
            advance();
        end
        check_eq("t4_count", delivered - base, 3);
        repeat (3) step();
        push_word(8'h55);
        advance();
        first = -1;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (out_valid && first < 0) begin
                first = k;
                check_eq("t4_late_data", out_data, 8'h55);
            end
            advance();
        end
        check_eq("t4_late_latency", first, 2);

        // Asynchronous reset while one word is buffered and another is in flight.
        for (int i = 0; i < 8; i++) push_word(8'hE0 + 8'(i));
        advance();
        step();
        step();
        check_eq("t5_pre_valid", out_valid, 1);
        check_eq("t5_pre_idle", idle, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", out_valid, 0);
        check_eq("t5_rst_rd_en", fifo_rd_en, 0);
        check_eq("t5_rst_idle", idle, 1);
        exp_q.delete();
        outstanding = 0;
        prev_hold = 1'b0;
        advance();
        advance();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check_eq("t5_post_valid", out_valid, 0);
            check_eq("t5_post_idle", idle, 1);
            advance();
        end
        base = delivered;
        push_word(8'h77);
        advance();
        repeat (6) step();
        check_eq("t5_fresh_count", delivered - base, 1);

        // Random writes and consumer readiness over 1000 words.
        base = delivered;
        written = 0;
        pct = 100;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (written >= 1000 && (delivered - base) >= 1000) break;
            if (cyc % 97 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 10;
                    1: pct = 50;
                    2: pct = 90;
                    default: pct = 100;
                endcase
            end
            if (written < 1000 && $urandom_range(0, 3) != 0) begin
                n = $urandom_range(1, 3);
                if (n > 1000 - written) n = 1000 - written;
                for (int i = 0; i < n; i++) push_word(8'($urandom));
                written += n;
            end
            out_ready = ($urandom_range(1, 100) <= pct);
            step();
        end
        check_eq("rand_delivered", delivered - base, 1000);
        check_eq("rand_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
